// File: rtl/ovr_i_mon.sv
// Over-current monitor: synchronizes the H-bridge OVR_I flags, blanks them after each PWM
// period start, and latches a motor shutdown after FAULT_LIM consecutive faulty periods.
// Define OVR_I_SIDE_LOG_EN to record which bridge side caused the trip (fault_lft/fault_rght).
// Debug outputs: dbg_state_o (0=NORM, 1=TRIP, 2=COOL) and dbg_fcnt_o (consecutive-fault count).
module ovr_i_mon #(
   parameter int BLANK_CYC = 128,
   parameter int FAULT_LIM = 4,
   parameter int COOL_PER  = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pwm_synch,
   input  logic       OVR_I_lft,
   input  logic       OVR_I_rght,
   input  logic       clr_fault,
   output logic       ovr_shtdwn,
   output logic       ovr_I_alert,
   output logic       fault_lft,
   output logic       fault_rght,
   output logic [1:0] dbg_state_o,
   output logic [3:0] dbg_fcnt_o
);

   localparam int BW = $clog2(BLANK_CYC + 1);

   typedef enum logic [1:0] {NORM = 2'd0, TRIP = 2'd1, COOL = 2'd2} state_t;

   logic          lft_meta_q, s_lft_q, rght_meta_q, s_rght_q;
   logic [BW-1:0] blank_q, blank_d;
   logic          pf_lft_q, pf_lft_d, pf_rght_q, pf_rght_d;
   logic          blank_done, qual_lft, qual_rght, faulty, trip_now;
   logic [4:0]    fcnt_inc;
   logic [3:0]    fcnt_sat;
   logic [8:0]    cool_inc;
   state_t        state_q;
   logic [3:0]    fcnt_q;
   logic [7:0]    cool_q;
   logic          shtdwn_q, alert_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         lft_meta_q  <= 1'b0;
         s_lft_q     <= 1'b0;
         rght_meta_q <= 1'b0;
         s_rght_q    <= 1'b0;
         blank_q     <= '0;
         pf_lft_q    <= 1'b0;
         pf_rght_q   <= 1'b0;
      end else begin
         lft_meta_q  <= OVR_I_lft;
         s_lft_q     <= lft_meta_q;
         rght_meta_q <= OVR_I_rght;
         s_rght_q    <= rght_meta_q;
         blank_q     <= blank_d;
         pf_lft_q    <= pf_lft_d;
         pf_rght_q   <= pf_rght_d;
      end
   end

   always_comb begin
      blank_d = blank_q;
      if (pwm_synch)
         blank_d = '0;
      else if (blank_q != BW'(BLANK_CYC))
         blank_d = blank_q + BW'(1);
   end

   // Period close wins over a qualification landing on the same cycle.
   assign blank_done = (blank_q == BW'(BLANK_CYC));
   assign qual_lft   = s_lft_q  & blank_done & ~pwm_synch;
   assign qual_rght  = s_rght_q & blank_done & ~pwm_synch;
   assign pf_lft_d   = pwm_synch ? 1'b0 : (pf_lft_q  | qual_lft);
   assign pf_rght_d  = pwm_synch ? 1'b0 : (pf_rght_q | qual_rght);

   assign faulty   = pf_lft_q | pf_rght_q;
   assign fcnt_inc = {1'b0, fcnt_q} + 5'd1;
   assign fcnt_sat = (fcnt_q == 4'hF) ? 4'hF : fcnt_inc[3:0];
   assign trip_now = faulty && (fcnt_inc >= 5'(FAULT_LIM));
   assign cool_inc = {1'b0, cool_q} + 9'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= NORM;
         fcnt_q   <= 4'd0;
         cool_q   <= 8'd0;
         shtdwn_q <= 1'b0;
         alert_q  <= 1'b0;
      end else begin
         alert_q <= 1'b0;
         if (pwm_synch)
            fcnt_q <= faulty ? fcnt_sat : 4'd0;
         case (state_q)
            NORM: begin
               if (pwm_synch && trip_now) begin
                  state_q  <= TRIP;
                  shtdwn_q <= 1'b1;
                  alert_q  <= 1'b1;
               end
            end
            TRIP: begin
               if (clr_fault) begin
                  state_q <= COOL;
                  cool_q  <= 8'd0;
                  fcnt_q  <= 4'd0;
               end
            end
            COOL: begin
               if (pwm_synch) begin
                  if (faulty) begin
                     state_q <= TRIP;
                     alert_q <= 1'b1;
                  end else if (cool_inc == 9'(COOL_PER)) begin
                     state_q  <= NORM;
                     shtdwn_q <= 1'b0;
                     fcnt_q   <= 4'd0;
                  end else begin
                     cool_q <= cool_inc[7:0];
                  end
               end
            end
            default: begin
               state_q  <= NORM;
               shtdwn_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef OVR_I_SIDE_LOG_EN
   logic fault_lft_q, fault_rght_q;

   // Snapshot the closing period's sides at the trip; accumulate on re-trips from COOL.
   always_ff @(posedge clk) begin
      if (rst) begin
         fault_lft_q  <= 1'b0;
         fault_rght_q <= 1'b0;
      end else begin
         case (state_q)
            NORM: begin
               if (pwm_synch && trip_now) begin
                  fault_lft_q  <= pf_lft_q;
                  fault_rght_q <= pf_rght_q;
               end
            end
            TRIP: begin
               if (clr_fault) begin
                  fault_lft_q  <= 1'b0;
                  fault_rght_q <= 1'b0;
               end
            end
            COOL: begin
               if (pwm_synch && faulty) begin
                  fault_lft_q  <= fault_lft_q  | pf_lft_q;
                  fault_rght_q <= fault_rght_q | pf_rght_q;
               end
            end
            default: begin
               fault_lft_q  <= 1'b0;
               fault_rght_q <= 1'b0;
            end
         endcase
      end
   end

   assign fault_lft  = fault_lft_q;
   assign fault_rght = fault_rght_q;
`else
   assign fault_lft  = 1'b0;
   assign fault_rght = 1'b0;
`endif

   assign ovr_shtdwn  = shtdwn_q;
   assign ovr_I_alert = alert_q;
   assign dbg_state_o = state_q;
   assign dbg_fcnt_o  = fcnt_q;

endmodule

// File: tb/tb_ovr_i_mon.sv
// Testbench for ovr_i_mon: directed vector table, hand-written multi-cycle sequences and
// randomized PWM periods, all checked cycle by cycle against a period-level reference model.
module tb_ovr_i_mon;

   localparam int BLANK_CYC = 128;
   localparam int FAULT_LIM = 4;
   localparam int COOL_PER  = 8;
   localparam int PERIOD    = 512;
   localparam int NORM = 0, TRIP = 1, COOL = 2;
`ifdef OVR_I_SIDE_LOG_EN
   localparam bit LOG_EN = 1'b1;
`else
   localparam bit LOG_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pwm_synch = 1'b0;
   logic       OVR_I_lft = 1'b0;
   logic       OVR_I_rght = 1'b0;
   logic       clr_fault = 1'b0;
   logic       ovr_shtdwn, ovr_I_alert, fault_lft, fault_rght;
   logic [1:0] dbg_state_o;
   logic [3:0] dbg_fcnt_o;

   always #5 clk = ~clk;

   ovr_i_mon dut (
      .clk        (clk),
      .rst        (rst),
      .pwm_synch  (pwm_synch),
      .OVR_I_lft  (OVR_I_lft),
      .OVR_I_rght (OVR_I_rght),
      .clr_fault  (clr_fault),
      .ovr_shtdwn (ovr_shtdwn),
      .ovr_I_alert(ovr_I_alert),
      .fault_lft  (fault_lft),
      .fault_rght (fault_rght),
      .dbg_state_o(dbg_state_o),
      .dbg_fcnt_o (dbg_fcnt_o)
   );

   int n_checks = 0;
   int n_err    = 0;
   int alert_cnt = 0;

   // Reference model: pin history, cycles since period start, per-period fault flags,
   // consecutive-fault count, operating mode and cool-down count.
   bit m_hl[2], m_hr[2];
   int m_age, m_cnt, m_mode, m_cool;
   bit m_pfl, m_pfr, m_shd, m_alert, m_fl, m_fr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit s, input bit l, input bit r, input bit c, input bit rs);
      bit ql, qr, faulty, to_cool;
      if (rs) begin
         m_hl = '{0, 0}; m_hr = '{0, 0};
         m_age = 0; m_cnt = 0; m_mode = NORM; m_cool = 0;
         m_pfl = 0; m_pfr = 0; m_shd = 0; m_alert = 0; m_fl = 0; m_fr = 0;
      end else begin
         ql = m_hl[0] && (m_age >= BLANK_CYC) && !s;
         qr = m_hr[0] && (m_age >= BLANK_CYC) && !s;
         faulty = m_pfl || m_pfr;
         to_cool = 0;
         m_alert = 0;
         case (m_mode)
            NORM: if (s && faulty && (m_cnt + 1 >= FAULT_LIM)) begin
               m_mode = TRIP; m_shd = 1; m_alert = 1; m_fl = m_pfl; m_fr = m_pfr;
            end
            TRIP: if (c) begin
               m_mode = COOL; m_cool = 0; m_fl = 0; m_fr = 0; to_cool = 1;
            end
            default: if (s) begin
               if (faulty) begin
                  m_mode = TRIP; m_alert = 1; m_fl = m_fl | m_pfl; m_fr = m_fr | m_pfr;
               end else begin
                  m_cool = m_cool + 1;
                  if (m_cool == COOL_PER) begin
                     m_mode = NORM; m_shd = 0;
                  end
               end
            end
         endcase
         if (to_cool) m_cnt = 0;
         else if (s) m_cnt = faulty ? ((m_cnt < 15) ? m_cnt + 1 : 15) : 0;
         if (s) begin
            m_pfl = 0; m_pfr = 0;
         end else begin
            m_pfl = m_pfl | ql; m_pfr = m_pfr | qr;
         end
         m_age = s ? 0 : ((m_age < BLANK_CYC) ? m_age + 1 : BLANK_CYC);
         m_hl[0] = m_hl[1]; m_hl[1] = l;
         m_hr[0] = m_hr[1]; m_hr[1] = r;
      end
   endtask

   task automatic tick(input bit s, input bit l, input bit r, input bit c, input bit rs);
      logic [31:0] act, exp;
      pwm_synch = s; OVR_I_lft = l; OVR_I_rght = r; clr_fault = c; rst = rs;
      @(posedge clk);
      model_step(s, l, r, c, rs);
      #1;
      act = {22'd0, ovr_shtdwn, ovr_I_alert, fault_lft, fault_rght, dbg_state_o, dbg_fcnt_o};
      exp = {22'd0, m_shd, m_alert, LOG_EN & m_fl, LOG_EN & m_fr, 2'(m_mode), 4'(m_cnt)};
      check("cycle", act, exp);
      if (ovr_I_alert) alert_cnt++;
   endtask

   task automatic do_reset();
      tick(0, 0, 0, 0, 1);
      tick(0, 0, 0, 0, 1);
      alert_cnt = 0;
   endtask

   // One PWM period: pwm_synch on cycle 0, fault pin high on [ws..we], clr_fault on cycle clr_c.
   task automatic run_period(input bit l, input bit r, input int ws, input int we,
                             input int clr_c, input int len);
      for (int c = 0; c < len; c++)
         tick(c == 0, l && c >= ws && c <= we, r && c >= ws && c <= we, c == clr_c, 0);
   endtask

   task automatic trip_left();
      do_reset();
      for (int p = 0; p < 4; p++) run_period(1, 0, 300, 400, -1, PERIOD);
   endtask

   typedef struct {
      int         nper;
      logic [15:0] lm;
      logic [15:0] rm;
      int         ws;
      int         we;
      bit         e_shd;
      int         e_alerts;
      bit         e_fl;
      bit         e_fr;
      int         e_fcnt;
      int         e_state;
   } vec_t;

   vec_t vecs[10];

   initial begin
      vecs[0] = '{10, 16'h03FF, 16'h0000,  10, 100, 0, 0, 0, 0, 0, NORM};
      vecs[1] = '{ 4, 16'h000F, 16'h0000, 300, 400, 1, 1, 1, 0, 4, TRIP};
      vecs[2] = '{ 7, 16'h0000, 16'h0077, 300, 400, 0, 0, 0, 0, 3, NORM};
      vecs[3] = '{ 4, 16'h000F, 16'h000F, 300, 400, 1, 1, 1, 1, 4, TRIP};
      vecs[4] = '{ 3, 16'h0000, 16'h0007, 300, 400, 0, 0, 0, 0, 3, NORM};
      vecs[5] = '{ 4, 16'h0005, 16'h000A, 300, 400, 1, 1, 0, 1, 4, TRIP};
      vecs[6] = '{ 4, 16'h000F, 16'h0000, 126, 126, 0, 0, 0, 0, 0, NORM};
      vecs[7] = '{ 4, 16'h000F, 16'h0000, 127, 127, 1, 1, 1, 0, 4, TRIP};
      vecs[8] = '{ 5, 16'h0000, 16'h001F, PERIOD-2, PERIOD-2, 0, 0, 0, 0, 0, NORM};
      vecs[9] = '{ 4, 16'h0000, 16'h000F, PERIOD-3, PERIOD-3, 1, 1, 0, 1, 4, TRIP};

      do_reset();
      check("reset_shtdwn", ovr_shtdwn, 0);
      check("reset_alert", ovr_I_alert, 0);
      check("reset_faults", {fault_lft, fault_rght}, 0);
      check("reset_state", dbg_state_o, NORM);

      for (int i = 0; i < 10; i++) begin
         do_reset();
         for (int p = 0; p < vecs[i].nper; p++)
            run_period(vecs[i].lm[p], vecs[i].rm[p], vecs[i].ws, vecs[i].we, -1, PERIOD);
         run_period(0, 0, 0, 0, -1, PERIOD);
         check($sformatf("v%0d_shtdwn", i), ovr_shtdwn, vecs[i].e_shd);
         check($sformatf("v%0d_alerts", i), alert_cnt, vecs[i].e_alerts);
         check($sformatf("v%0d_fault_lft", i), fault_lft, LOG_EN & vecs[i].e_fl);
         check($sformatf("v%0d_fault_rght", i), fault_rght, LOG_EN & vecs[i].e_fr);
         check($sformatf("v%0d_fcnt", i), dbg_fcnt_o, vecs[i].e_fcnt);
         check($sformatf("v%0d_state", i), dbg_state_o, vecs[i].e_state);
      end

      // Recovery: trip, clr_fault mid-period, shutdown drops right after the 8th clean synch.
      trip_left();
      run_period(0, 0, 0, 0, 50, PERIOD);
      check("rec_alerts", alert_cnt, 1);
      check("rec_state_cool", dbg_state_o, COOL);
      for (int p = 0; p < 7; p++) run_period(0, 0, 0, 0, -1, PERIOD);
      check("rec_shtdwn_7", ovr_shtdwn, 1);
      check("rec_state_7", dbg_state_o, COOL);
      tick(1, 0, 0, 0, 0);
      check("rec_shtdwn_8", ovr_shtdwn, 0);
      check("rec_state_8", dbg_state_o, NORM);
      for (int c = 1; c < PERIOD; c++) tick(0, 0, 0, 0, 0);

      // Fault in the third cool period re-trips with a second alert.
      trip_left();
      run_period(0, 0, 0, 0, 50, PERIOD);
      run_period(0, 0, 0, 0, -1, PERIOD);
      run_period(1, 0, 300, 400, -1, PERIOD);
      tick(1, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 0);
      check("cool_retrip_state", dbg_state_o, TRIP);
      check("cool_retrip_alerts", alert_cnt, 2);
      check("cool_retrip_shtdwn", ovr_shtdwn, 1);
      check("cool_retrip_fault_lft", fault_lft, LOG_EN);

      // Reset in the middle of COOL.
      tick(0, 0, 0, 1, 0);
      for (int c = 0; c < 20; c++) tick(0, 0, 0, 0, 0);
      check("midcool_state", dbg_state_o, COOL);
      tick(0, 0, 0, 0, 1);
      check("midcool_rst_shtdwn", ovr_shtdwn, 0);
      check("midcool_rst_faults", {fault_lft, fault_rght}, 0);
      check("midcool_rst_state", dbg_state_o, NORM);
      check("midcool_rst_fcnt", dbg_fcnt_o, 0);
      for (int p = 0; p < 2; p++) run_period(1, 1, 300, 400, -1, PERIOD);

      // clr_fault on the trip cycle is ignored.
      trip_left();
      run_period(0, 0, 0, 0, 0, PERIOD);
      check("clr_on_trip_state", dbg_state_o, TRIP);
      check("clr_on_trip_shtdwn", ovr_shtdwn, 1);
      check("clr_on_trip_alerts", alert_cnt, 1);

      // Random periods: fault-heavy first half, mostly clean second half.
      do_reset();
      for (int it = 0; it < 40; it++) begin
         int len, ws, we, clr_c, pf;
         bit l, r;
         len = $urandom_range(150, 600);
         pf  = (it < 20) ? 3 : 1;
         l   = ($urandom_range(0, 3) < pf);
         r   = ($urandom_range(0, 3) < pf);
         ws  = $urandom_range(0, len - 1);
         we  = ws + $urandom_range(0, 120);
         clr_c = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1;
         run_period(l, r, ws, we, clr_c, len);
         if ($urandom_range(0, 24) == 0) tick(0, 0, 0, 0, 1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
